// File: rtl/mrna_iso_valve_sequencer_if.sv
// Run-control handshake between the host and the mRNA isolation valve sequencer.
// The pause line exists only when MRNAISO_SEQ_PAUSE_EN is defined.
interface mrna_iso_valve_sequencer_if;
  logic       start;
  logic       abort;
`ifdef MRNAISO_SEQ_PAUSE_EN
  logic       pause;
`endif
  logic       busy;
  logic       done;
  logic [2:0] phase;

  modport master (
    output start, abort,
`ifdef MRNAISO_SEQ_PAUSE_EN
    output pause,
`endif
    input  busy, done, phase
  );

  modport slave (
    input  start, abort,
`ifdef MRNAISO_SEQ_PAUSE_EN
    input  pause,
`endif
    output busy, done, phase
  );
endinterface

// File: rtl/mrna_iso_valve_sequencer.sv
// Pneumatic valve/pump sequencer for one 3-lane mRNA isolation run (1 = pressurised = closed).
// Define MRNAISO_SEQ_PAUSE_EN to add the pause input that freezes a run in place.
module mrna_iso_valve_sequencer #(
  parameter int TW        = 16,
  parameter int T_LOAD    = 200,
  parameter int T_MIX     = 1000,
  parameter int T_WASH    = 400,
  parameter int T_COLLECT = 300,
  parameter int PUMP_DIV  = 10
) (
  input  logic clk,
  input  logic rst_n,
  mrna_iso_valve_sequencer_if.slave seq,
  output logic cells_in_ctl,
  output logic cells_out_ctl,
  output logic collect_ctl,
  output logic lysis_in_ctl,
  output logic lysis_waste_ctl,
  output logic beads_in_ctl,
  output logic bead_waste_ctl,
  output logic push_ctl,
  output logic sep_ctl,
  output logic sieve_ctl,
  output logic waste_ctl,
  output logic pump_1,
  output logic pump_2,
  output logic pump_3
);
  localparam int DW = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_CELLS, LYSE, MIX, BEADS, BIND, WASH, COLLECT} state_t;

  typedef struct packed {
    logic       cells_in, cells_out, collect, lysis_in, lysis_waste;
    logic       beads_in, bead_waste, push, sep, sieve, waste;
    logic [2:0] pump;
  } valve_t;

  // Pause closes everything except sep/sieve, which keep the beads where they are.
  localparam valve_t HOLD_MASK = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                   1'b0, 1'b0, 1'b1, 3'b111};

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d, last;
  logic [DW-1:0]   div_q, div_d;
  logic [2:0]      step_q, step_d;
  valve_t          vlv_q, vlv_d;
  logic            busy_q, done_q, done_d, hold;

`ifdef MRNAISO_SEQ_PAUSE_EN
  assign hold = seq.pause && (state_q != IDLE);
`else
  assign hold = 1'b0;
`endif

  function automatic logic [2:0] pump_pat(input logic [2:0] s);
    case (s)
      3'd0:    return 3'b011;
      3'd1:    return 3'b001;
      3'd2:    return 3'b101;
      3'd3:    return 3'b100;
      3'd4:    return 3'b110;
      default: return 3'b010;
    endcase
  endfunction

  always_comb begin
    case (state_q)
      LOAD_CELLS, LYSE, BEADS: last = TW'(T_LOAD - 1);
      MIX, BIND:               last = TW'(T_MIX - 1);
      WASH:                    last = TW'(T_WASH - 1);
      COLLECT:                 last = TW'(T_COLLECT - 1);
      default:                 last = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    div_d   = div_q;
    step_d  = step_q;
    done_d  = 1'b0;
    if (seq.abort) begin
      state_d = IDLE;
      timer_d = '0;
      div_d   = '0;
      step_d  = '0;
    end else if (state_q == IDLE) begin
      if (seq.start) state_d = LOAD_CELLS;
    end else if (!hold) begin
      if (timer_q == last) begin
        state_d = (state_q == COLLECT) ? IDLE : state_t'(state_q + 3'd1);
        done_d  = (state_q == COLLECT);
        timer_d = '0;
        div_d   = '0;
        step_d  = '0;
      end else begin
        timer_d = timer_q + 1'b1;
        if (div_q == DW'(PUMP_DIV - 1)) begin
          div_d  = '0;
          step_d = (step_q == 3'd5) ? 3'd0 : step_q + 3'd1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge as the state.
  always_comb begin
    vlv_d = '1;
    if (state_d != IDLE) begin
      vlv_d.sep   = 1'b0;
      vlv_d.sieve = 1'b0;
      case (state_d)
        LOAD_CELLS: begin vlv_d.cells_in = 1'b0; vlv_d.cells_out   = 1'b0; end
        LYSE:       begin vlv_d.lysis_in = 1'b0; vlv_d.lysis_waste = 1'b0; end
        BEADS:      begin vlv_d.beads_in = 1'b0; vlv_d.bead_waste  = 1'b0; end
        WASH:       begin vlv_d.push = 1'b0; vlv_d.waste   = 1'b0; vlv_d.sep = 1'b1; vlv_d.sieve = 1'b1; end
        COLLECT:    begin vlv_d.push = 1'b0; vlv_d.collect = 1'b0; vlv_d.sep = 1'b1; vlv_d.sieve = 1'b1; end
        default: ;
      endcase
      if (state_d inside {LOAD_CELLS, LYSE, MIX, BEADS, BIND}) vlv_d.pump = pump_pat(step_d);
      if (hold) vlv_d = vlv_d | HOLD_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      div_q   <= '0;
      step_q  <= '0;
      vlv_q   <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      div_q   <= div_d;
      step_q  <= step_d;
      vlv_q   <= vlv_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
    end
  end

  assign seq.busy        = busy_q;
  assign seq.done        = done_q;
  assign seq.phase       = state_q;
  assign cells_in_ctl    = vlv_q.cells_in;
  assign cells_out_ctl   = vlv_q.cells_out;
  assign collect_ctl     = vlv_q.collect;
  assign lysis_in_ctl    = vlv_q.lysis_in;
  assign lysis_waste_ctl = vlv_q.lysis_waste;
  assign beads_in_ctl    = vlv_q.beads_in;
  assign bead_waste_ctl  = vlv_q.bead_waste;
  assign push_ctl        = vlv_q.push;
  assign sep_ctl         = vlv_q.sep;
  assign sieve_ctl       = vlv_q.sieve;
  assign waste_ctl       = vlv_q.waste;
  assign {pump_1, pump_2, pump_3} = vlv_q.pump;

  // An open inlet while the collect port is open would contaminate the eluate.
  always_ff @(posedge clk) begin
    if (rst_n) assert (collect_ctl || (cells_in_ctl && lysis_in_ctl && beads_in_ctl));
  end
endmodule

// File: tb/tb_mrna_iso_valve_sequencer.sv
// Directed bench for mrna_iso_valve_sequencer with short phase timings (4/6/3/2, pump step every 2).
module tb_mrna_iso_valve_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cells_in_ctl, cells_out_ctl, collect_ctl, lysis_in_ctl, lysis_waste_ctl;
  logic beads_in_ctl, bead_waste_ctl, push_ctl, sep_ctl, sieve_ctl, waste_ctl;
  logic pump_1, pump_2, pump_3;

  mrna_iso_valve_sequencer_if seq_if();

  mrna_iso_valve_sequencer #(
    .TW(16), .T_LOAD(4), .T_MIX(6), .T_WASH(3), .T_COLLECT(2), .PUMP_DIV(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .seq(seq_if),
    .cells_in_ctl(cells_in_ctl), .cells_out_ctl(cells_out_ctl), .collect_ctl(collect_ctl),
    .lysis_in_ctl(lysis_in_ctl), .lysis_waste_ctl(lysis_waste_ctl), .beads_in_ctl(beads_in_ctl),
    .bead_waste_ctl(bead_waste_ctl), .push_ctl(push_ctl), .sep_ctl(sep_ctl),
    .sieve_ctl(sieve_ctl), .waste_ctl(waste_ctl),
    .pump_1(pump_1), .pump_2(pump_2), .pump_3(pump_3)
  );

  always #5 clk = ~clk;

  wire [10:0] ctl_v  = {cells_in_ctl, cells_out_ctl, collect_ctl, lysis_in_ctl, lysis_waste_ctl,
                        beads_in_ctl, bead_waste_ctl, push_ctl, sep_ctl, sieve_ctl, waste_ctl};
  wire [2:0]  pump_v = {pump_1, pump_2, pump_3};

  int n_tests = 0;
  int n_fail  = 0;

  int          busy_cyc, done_cnt, extra_busy, extra_done, mix_n, mix_ctl_bad, pz_bad, pz_seen;
  int          dwell [8];
  bit          done_at_end, tmo;
  logic [13:0] end_out;
  logic [10:0] ph_ctl  [8];
  logic [2:0]  ph_pump [8];
  logic [2:0]  mix_pump[6];

  int          exp_dw  [8] = '{0, 4, 4, 6, 4, 6, 3, 2};
  logic [10:0] exp_ctl [8] = '{11'b11111111111, 11'b00111111001, 11'b11100111001, 11'b11111111001,
                               11'b11111001001, 11'b11111111001, 11'b11111110110, 11'b11011110111};
  logic [2:0]  exp_pump[8] = '{3'b111, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b111, 3'b111};
  logic [2:0]  exp_mix [6] = '{3'b011, 3'b011, 3'b001, 3'b001, 3'b101, 3'b101};

  // Pulses start, then samples every falling edge until busy drops, optionally injecting a
  // stray start, an abort or a pause at a given (phase, cycle-in-phase).
  task automatic capture_run(input int st_ph, input int ab_ph, input int ab_cyc,
                             input int pz_ph, input int pz_cyc, input int pz_len);
    int guard, pz_left, p;
    bit st_done, pz_done;
    busy_cyc = 0; done_cnt = 0; extra_busy = 0; extra_done = 0; tmo = 0; done_at_end = 0;
    mix_n = 0; mix_ctl_bad = 0; pz_bad = 0; pz_seen = 0; end_out = '0;
    guard = 0; pz_left = 0; st_done = 0; pz_done = 0;
    for (int i = 0; i < 8; i++) begin dwell[i] = 0; ph_ctl[i] = 'x; ph_pump[i] = 'x; end
    @(posedge clk); #1 seq_if.start = 1'b1;
    @(posedge clk); #1 seq_if.start = 1'b0;
    forever begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin tmo = 1; break; end
      if (seq_if.busy !== 1'b1) begin
        done_at_end = seq_if.done;
        end_out     = {ctl_v, pump_v};
        break;
      end
      busy_cyc++;
      p = int'(seq_if.phase);
      if (seq_if.done === 1'b1) done_cnt++;
      if (dwell[p] == 0) begin ph_ctl[p] = ctl_v; ph_pump[p] = pump_v; end
      dwell[p]++;
      if (p == 3) begin
        if (mix_n < 6) mix_pump[mix_n] = pump_v;
        mix_n++;
        if (ctl_v !== 11'b11111111001) mix_ctl_bad++;
      end
      seq_if.start = 1'b0;
      if (st_ph != 0 && !st_done && p == st_ph) begin seq_if.start = 1'b1; st_done = 1; end
      if (ab_ph != 0 && p == ab_ph && dwell[p] == ab_cyc) seq_if.abort = 1'b1;
`ifdef MRNAISO_SEQ_PAUSE_EN
      if (pz_left > 0) begin
        pz_seen++;
        if ({ctl_v[10:3], ctl_v[0], pump_v} !== 12'hFFF || ctl_v[2:1] !== 2'b00) pz_bad++;
        pz_left--;
        if (pz_left == 0) seq_if.pause = 1'b0;
      end else if (pz_ph != 0 && !pz_done && p == pz_ph && dwell[p] == pz_cyc) begin
        seq_if.pause = 1'b1; pz_left = pz_len; pz_done = 1;
      end
`else
      if (pz_ph != 0 || pz_cyc != 0 || pz_len != 0) pz_left = 0;
`endif
    end
    seq_if.start = 1'b0;
    seq_if.abort = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (seq_if.busy !== 1'b0) extra_busy++;
      if (seq_if.done !== 1'b0) extra_done++;
    end
  endtask

  task automatic test_reset;
    int bad;
    rst_n = 1'b0; seq_if.start = 1'b1; seq_if.abort = 1'b0;
`ifdef MRNAISO_SEQ_PAUSE_EN
    seq_if.pause = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if ({ctl_v, pump_v} !== 14'h3FFF) begin n_fail++; $display("FAIL reset_outputs: got %b expected %b", {ctl_v, pump_v}, 14'h3FFF); end
    n_tests++; if (seq_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", seq_if.busy); end
    n_tests++; if (seq_if.phase !== 3'd0) begin n_fail++; $display("FAIL reset_phase: got %0d expected 0", seq_if.phase); end
    n_tests++; if (seq_if.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", seq_if.done); end
    seq_if.start = 1'b0; rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if ({ctl_v, pump_v} !== 14'h3FFF || seq_if.busy !== 1'b0 || seq_if.phase !== 3'd0) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL idle_hold: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_run_timing;
    capture_run(0, 0, 0, 0, 0, 0);
    n_tests++; if (tmo) begin n_fail++; $display("FAIL run_timeout: got timeout expected completion"); end
    n_tests++; if (busy_cyc != 29) begin n_fail++; $display("FAIL run_len: got %0d expected 29", busy_cyc); end
    n_tests++; if (done_at_end !== 1'b1) begin n_fail++; $display("FAIL done_pulse: got %b expected 1", done_at_end); end
    n_tests++; if (done_cnt + extra_done != 0) begin n_fail++; $display("FAIL done_extra: got %0d expected 0", done_cnt + extra_done); end
    n_tests++; if (extra_busy != 0) begin n_fail++; $display("FAIL idle_after: got %0d expected 0", extra_busy); end
    n_tests++; if (end_out !== 14'h3FFF) begin n_fail++; $display("FAIL end_outputs: got %b expected %b", end_out, 14'h3FFF); end
    for (int p = 1; p < 8; p++) begin
      n_tests++; if (dwell[p] != exp_dw[p]) begin n_fail++; $display("FAIL dwell_%0d: got %0d expected %0d", p, dwell[p], exp_dw[p]); end
      n_tests++; if (ph_ctl[p] !== exp_ctl[p]) begin n_fail++; $display("FAIL ctl_%0d: got %b expected %b", p, ph_ctl[p], exp_ctl[p]); end
      n_tests++; if (ph_pump[p] !== exp_pump[p]) begin n_fail++; $display("FAIL pump_%0d: got %b expected %b", p, ph_pump[p], exp_pump[p]); end
    end
  endtask

  task automatic test_pump_mix;
    capture_run(0, 0, 0, 0, 0, 0);
    n_tests++; if (mix_n != 6) begin n_fail++; $display("FAIL mix_len: got %0d expected 6", mix_n); end
    for (int i = 0; i < 6; i++) begin
      n_tests++; if (mix_pump[i] !== exp_mix[i]) begin n_fail++; $display("FAIL mix_pump_%0d: got %b expected %b", i, mix_pump[i], exp_mix[i]); end
    end
    n_tests++; if (mix_ctl_bad != 0) begin n_fail++; $display("FAIL mix_ctl: got %0d bad cycles expected 0", mix_ctl_bad); end
  endtask

  task automatic test_abort;
    capture_run(0, 5, 2, 0, 0, 0);
    n_tests++; if (busy_cyc != 20) begin n_fail++; $display("FAIL abort_len: got %0d expected 20", busy_cyc); end
    n_tests++; if (done_at_end !== 1'b0 || extra_done != 0) begin n_fail++; $display("FAIL abort_done: got %b/%0d expected 0/0", done_at_end, extra_done); end
    n_tests++; if (end_out !== 14'h3FFF) begin n_fail++; $display("FAIL abort_outputs: got %b expected %b", end_out, 14'h3FFF); end
    capture_run(0, 0, 0, 0, 0, 0);
    n_tests++; if (busy_cyc != 29) begin n_fail++; $display("FAIL post_abort_len: got %0d expected 29", busy_cyc); end
    n_tests++; if (done_at_end !== 1'b1) begin n_fail++; $display("FAIL post_abort_done: got %b expected 1", done_at_end); end
  endtask

  task automatic test_start_ignored;
    capture_run(6, 0, 0, 0, 0, 0);
    n_tests++; if (busy_cyc != 29) begin n_fail++; $display("FAIL busy_start_len: got %0d expected 29", busy_cyc); end
    n_tests++; if (dwell[6] != 3) begin n_fail++; $display("FAIL busy_start_wash: got %0d expected 3", dwell[6]); end
    n_tests++; if (extra_busy != 0) begin n_fail++; $display("FAIL busy_start_restart: got %0d expected 0", extra_busy); end
  endtask

`ifdef MRNAISO_SEQ_PAUSE_EN
  task automatic test_pause;
    capture_run(0, 0, 0, 2, 2, 5);
    n_tests++; if (busy_cyc != 34) begin n_fail++; $display("FAIL pause_len: got %0d expected 34", busy_cyc); end
    n_tests++; if (dwell[2] != 9) begin n_fail++; $display("FAIL pause_lyse: got %0d expected 9", dwell[2]); end
    n_tests++; if (dwell[3] != 6) begin n_fail++; $display("FAIL pause_mix: got %0d expected 6", dwell[3]); end
    n_tests++; if (pz_seen != 5) begin n_fail++; $display("FAIL pause_seen: got %0d expected 5", pz_seen); end
    n_tests++; if (pz_bad != 0) begin n_fail++; $display("FAIL pause_outputs: got %0d bad cycles expected 0", pz_bad); end
    n_tests++; if (done_at_end !== 1'b1) begin n_fail++; $display("FAIL pause_done: got %b expected 1", done_at_end); end
  endtask
`endif

  task automatic test_reset_midrun;
    @(posedge clk); #1 seq_if.start = 1'b1;
    @(posedge clk); #1 seq_if.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_tests++; if ({ctl_v, pump_v} !== 14'h3FFF) begin n_fail++; $display("FAIL midrst_outputs: got %b expected %b", {ctl_v, pump_v}, 14'h3FFF); end
    n_tests++; if (seq_if.busy !== 1'b0 || seq_if.phase !== 3'd0) begin n_fail++; $display("FAIL midrst_state: got busy=%b phase=%0d expected busy=0 phase=0", seq_if.busy, seq_if.phase); end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset;
    test_run_timing;
    test_pump_mix;
    test_abort;
    test_start_ignored;
`ifdef MRNAISO_SEQ_PAUSE_EN
    test_pause;
`endif
    test_reset_midrun;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
